// File: rtl/serial_operand_loader_pkg.sv
// Shared types and sizing helpers for the serial operand loader.
package serial_operand_loader_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } loader_state_t;

    // Width needed to count 0..data_width inclusive.
    function automatic int count_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// One operand lane: shifts serial bits in from the MSB side so the first bit ends at index 0.
module serial_shift_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {bit_in, data[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_operand_loader.sv
// Collects two LSB-first serial operands and hands complete pairs to a
// single-entry output register with a valid/ready handshake.
module serial_operand_loader
    import serial_operand_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic                                  in_a,
    input  logic                                  in_b,
    input  logic                                  in_clear,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_a,
    output logic [DATA_WIDTH-1:0]                 out_b,
    output logic [count_width(DATA_WIDTH)-1:0]    bit_count
);

    localparam int COUNT_W = count_width(DATA_WIDTH);

    loader_state_t         state;
    loader_state_t         next_state;
    logic                  accept;
    logic                  clear_frame;
    logic                  transfer;
    logic                  frame_last;
    logic [DATA_WIDTH-1:0] shift_a;
    logic [DATA_WIDTH-1:0] shift_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (accept && frame_last) next_state = FULL;
            FULL:    if (transfer)             next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // in_ready depends only on state, so in_valid never reaches it combinationally.
    always_comb begin
        in_ready    = (state == COLLECT);
        clear_frame = in_clear && (state == COLLECT);
        accept      = in_valid && (state == COLLECT) && !in_clear;
        transfer    = (state == FULL) && (!out_valid || out_ready);
        frame_last  = (bit_count == COUNT_W'(DATA_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
        end else if (clear_frame || transfer) begin
            bit_count <= '0;
        end else if (accept) begin
            bit_count <= bit_count + COUNT_W'(1);
        end
    end

    // A transfer and a consume in the same cycle keep out_valid high with the new pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_a     <= shift_a;
            out_b     <= shift_b;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    serial_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shift_a (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .clear    (clear_frame),
        .bit_in   (in_a),
        .data     (shift_a)
    );

    serial_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shift_b (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .clear    (clear_frame),
        .bit_in   (in_b),
        .data     (shift_b)
    );

endmodule

// File: tb/tb_serial_operand_loader.sv
// Bench for serial_operand_loader: directed scenarios on an 8-bit instance and
// a randomized scoreboard run on a 32-bit instance.
module tb_serial_operand_loader;

    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad = 0;

    logic       in_valid, in_a, in_b, in_clear, out_ready;
    logic       in_ready, out_valid;
    logic [7:0] out_a, out_b;
    logic [3:0] bit_count;

    logic        in_valid32, in_a32, in_b32, in_clear32, out_ready32;
    logic        in_ready32, out_valid32;
    logic [31:0] out_a32, out_b32;
    logic [5:0]  bit_count32;

    always #5 clk = ~clk;

    serial_operand_loader #(.DATA_WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clear  (in_clear),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .bit_count (bit_count)
    );

    serial_operand_loader #(.DATA_WIDTH(32)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid32),
        .in_a      (in_a32),
        .in_b      (in_b32),
        .in_clear  (in_clear32),
        .in_ready  (in_ready32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_a     (out_a32),
        .out_b     (out_b32),
        .bit_count (bit_count32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_a     = a[i];
            in_b     = b[i];
            step();
        end
        in_valid = 1'b0;
        in_a     = 1'b0;
        in_b     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++;
        if ({in_ready, out_valid, out_a, out_b, bit_count} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'd0}) begin
            bad++;
            $display("[TB] FAIL reset8: got rdy=%0b vld=%0b a=%h b=%h cnt=%0d, want rdy=1 vld=0 a=00 b=00 cnt=0",
                     in_ready, out_valid, out_a, out_b, bit_count);
        end
        total++;
        if ({in_ready32, out_valid32, out_a32, out_b32, bit_count32} !== {1'b1, 1'b0, 32'h0, 32'h0, 6'd0}) begin
            bad++;
            $display("[TB] FAIL reset32: got rdy=%0b vld=%0b a=%h b=%h cnt=%0d, want rdy=1 vld=0 a=0 b=0 cnt=0",
                     in_ready32, out_valid32, out_a32, out_b32, bit_count32);
        end
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        send_frame(8'hA5, 8'h3C);
        total++;
        if (out_valid !== 1'b0 || bit_count !== 4'd8 || in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_full: got vld=%0b cnt=%0d rdy=%0b, want vld=0 cnt=8 rdy=0",
                     out_valid, bit_count, in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'hA5 || out_b !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL single_data: got vld=%0b a=%h b=%h, want vld=1 a=a5 b=3c", out_valid, out_a, out_b);
        end
        total++;
        if (bit_count !== 4'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_restart: got cnt=%0d rdy=%0b, want cnt=0 rdy=1", bit_count, in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_pulse: got vld=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_frame(8'h11, 8'h22);
        step();
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'h11 || out_b !== 8'h22) begin
            bad++;
            $display("[TB] FAIL bp_first: got vld=%0b a=%h b=%h, want vld=1 a=11 b=22", out_valid, out_a, out_b);
        end
        send_frame(8'h33, 8'h44);
        total++;
        if (in_ready !== 1'b0 || bit_count !== 4'd8 || out_valid !== 1'b1 || out_a !== 8'h11 || out_b !== 8'h22) begin
            bad++;
            $display("[TB] FAIL bp_stall: got rdy=%0b cnt=%0d vld=%0b a=%h b=%h, want rdy=0 cnt=8 vld=1 a=11 b=22",
                     in_ready, bit_count, out_valid, out_a, out_b);
        end
        // Bits offered while the loader is full must be ignored.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = 1'($urandom);
            in_b     = 1'($urandom);
            step();
            total++;
            if (in_ready !== 1'b0 || bit_count !== 4'd8 || out_valid !== 1'b1 || out_a !== 8'h11 || out_b !== 8'h22) begin
                bad++;
                $display("[TB] FAIL bp_hold: got rdy=%0b cnt=%0d vld=%0b a=%h b=%h, want rdy=0 cnt=8 vld=1 a=11 b=22",
                         in_ready, bit_count, out_valid, out_a, out_b);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'h33 || out_b !== 8'h44) begin
            bad++;
            $display("[TB] FAIL bp_second: got vld=%0b a=%h b=%h, want vld=1 a=33 b=44", out_valid, out_a, out_b);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_drain: got vld=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 1'($urandom);
            in_b     = 1'($urandom);
            step();
        end
        total++;
        if (bit_count !== 4'd5) begin
            bad++;
            $display("[TB] FAIL clear_pre: got cnt=%0d, want 5", bit_count);
        end
        in_clear = 1'b1;
        in_valid = 1'b1;
        step();
        in_clear = 1'b0;
        in_valid = 1'b0;
        total++;
        if (bit_count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_post: got cnt=%0d rdy=%0b vld=%0b, want cnt=0 rdy=1 vld=0",
                     bit_count, in_ready, out_valid);
        end
        send_frame(8'hFF, 8'h01);
        total++;
        if (bit_count !== 4'd8) begin
            bad++;
            $display("[TB] FAIL clear_refill: got cnt=%0d, want 8", bit_count);
        end
        // A clear while the frame is complete has no effect.
        in_clear = 1'b1;
        step();
        in_clear = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'hFF || out_b !== 8'h01) begin
            bad++;
            $display("[TB] FAIL clear_data: got vld=%0b a=%h b=%h, want vld=1 a=ff b=01", out_valid, out_a, out_b);
        end
        step();
    endtask

    task automatic test_reset_recovery();
        logic stale;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 1'($urandom);
            in_b     = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        total++;
        if ({in_ready, out_valid, out_a, out_b, bit_count} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'd0}) begin
            bad++;
            $display("[TB] FAIL rst_mid: got rdy=%0b vld=%0b a=%h b=%h cnt=%0d, want rdy=1 vld=0 a=00 b=00 cnt=0",
                     in_ready, out_valid, out_a, out_b, bit_count);
        end
        out_ready = 1'b0;
        send_frame(8'h5A, 8'hC3);
        step();
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'h5A || out_b !== 8'hC3) begin
            bad++;
            $display("[TB] FAIL rst_refill: got vld=%0b a=%h b=%h, want vld=1 a=5a b=c3", out_valid, out_a, out_b);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({in_ready, out_valid, out_a, out_b, bit_count} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'd0}) begin
            bad++;
            $display("[TB] FAIL rst_full: got rdy=%0b vld=%0b a=%h b=%h cnt=%0d, want rdy=1 vld=0 a=00 b=00 cnt=0",
                     in_ready, out_valid, out_a, out_b, bit_count);
        end
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_stale: got stale frame=%0b, want 0", stale);
        end
    endtask

    // Scoreboard run: random in_valid and out_ready, frames checked in order on each handshake.
    task automatic test_random_stream();
        logic [31:0] exp_a[4];
        logic [31:0] exp_b[4];
        logic [31:0] pa, pb;
        logic        stall, accepted;
        int          fidx, bidx, got, cycles, prev_cnt, cnt;
        exp_a[0] = 32'hDEADBEEF;
        exp_b[0] = 32'h12345678;
        for (int f = 1; f < 4; f++) begin
            exp_a[f] = $urandom;
            exp_b[f] = $urandom;
        end
        fidx = 0; bidx = 0; got = 0; cycles = 0; prev_cnt = 0;
        stall = 1'b0; pa = '0; pb = '0;
        while (got < 4 && cycles < 4000) begin
            if (stall) begin
                total++;
                if (out_valid32 !== 1'b1 || out_a32 !== pa || out_b32 !== pb) begin
                    bad++;
                    $display("[TB] FAIL hold32: got vld=%0b a=%h b=%h, want vld=1 a=%h b=%h",
                             out_valid32, out_a32, out_b32, pa, pb);
                end
            end
            cnt = int'(bit_count32);
            if (bidx != 0) begin
                total++;
                if (cnt != bidx) begin
                    bad++;
                    $display("[TB] FAIL count32: got cnt=%0d, want %0d", cnt, bidx);
                end
            end
            total++;
            if (!(cnt == prev_cnt || cnt == prev_cnt + 1 || (prev_cnt == 32 && cnt == 0))) begin
                bad++;
                $display("[TB] FAIL monotonic32: got cnt=%0d after %0d, want same, +1, or 32->0", cnt, prev_cnt);
            end
            prev_cnt = cnt;
            out_ready32 = (fidx >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_valid32 && out_ready32) begin
                total++;
                if (out_a32 !== exp_a[got] || out_b32 !== exp_b[got]) begin
                    bad++;
                    $display("[TB] FAIL frame32_%0d: got a=%h b=%h, want a=%h b=%h",
                             got, out_a32, out_b32, exp_a[got], exp_b[got]);
                end
                got++;
            end
            stall = out_valid32 && !out_ready32;
            pa    = out_a32;
            pb    = out_b32;
            if (fidx < 4) begin
                in_valid32 = 1'($urandom_range(0, 1));
                in_a32     = exp_a[fidx][bidx];
                in_b32     = exp_b[fidx][bidx];
                accepted   = in_valid32 && in_ready32;
            end else begin
                in_valid32 = 1'b0;
                accepted   = 1'b0;
            end
            step();
            cycles++;
            if (accepted) begin
                bidx++;
                if (bidx == 32) begin
                    bidx = 0;
                    fidx++;
                end
            end
        end
        in_valid32 = 1'b0;
        total++;
        if (got != 4) begin
            bad++;
            $display("[TB] FAIL timeout32: got %0d frames, want 4", got);
        end
    endtask

    // Continuous streaming: one pair every 9 cycles, in order.
    task automatic test_back_to_back();
        logic [7:0] exp_a[4];
        logic [7:0] exp_b[4];
        logic       accepted;
        int         fidx, bidx, got, cycles, last_cycle;
        for (int f = 0; f < 4; f++) begin
            exp_a[f] = 8'($urandom);
            exp_b[f] = 8'($urandom);
        end
        out_ready = 1'b1;
        fidx = 0; bidx = 0; got = 0; cycles = 0; last_cycle = 0;
        while (got < 4 && cycles < 200) begin
            if (out_valid === 1'b1) begin
                total++;
                if (out_a !== exp_a[got] || out_b !== exp_b[got]) begin
                    bad++;
                    $display("[TB] FAIL b2b_data_%0d: got a=%h b=%h, want a=%h b=%h",
                             got, out_a, out_b, exp_a[got], exp_b[got]);
                end
                if (got > 0) begin
                    total++;
                    if (cycles - last_cycle != 9) begin
                        bad++;
                        $display("[TB] FAIL b2b_gap_%0d: got %0d cycles, want 9", got, cycles - last_cycle);
                    end
                end
                last_cycle = cycles;
                got++;
            end
            if (fidx < 4) begin
                in_valid = 1'b1;
                in_a     = exp_a[fidx][bidx];
                in_b     = exp_b[fidx][bidx];
                accepted = in_ready;
            end else begin
                in_valid = 1'b0;
                accepted = 1'b0;
            end
            step();
            cycles++;
            if (accepted) begin
                bidx++;
                if (bidx == 8) begin
                    bidx = 0;
                    fidx++;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (got != 4) begin
            bad++;
            $display("[TB] FAIL b2b_timeout: got %0d frames, want 4", got);
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_a        = 1'b0;
        in_b        = 1'b0;
        in_clear    = 1'b0;
        out_ready   = 1'b0;
        in_valid32  = 1'b0;
        in_a32      = 1'b0;
        in_b32      = 1'b0;
        in_clear32  = 1'b0;
        out_ready32 = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_clear();
        test_reset_recovery();
        test_random_stream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
